// File: rtl/deser8_pkg.sv
// Shared constants for the 8-bit serial-to-parallel deserializer.
package deser8_pkg;
  localparam int WORD_W = 8;
  localparam int IDX_W  = 3;
endpackage

// File: rtl/deser8.sv
// Serial-to-parallel converter: collects 8 sampled bits into a word and
// presents it on a registered valid/ready output with a sticky overrun flag.
module deser8
  import deser8_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              sin_valid,
  input  logic              align,
  input  logic              dout_ready,
  input  logic              ovr_clr,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  output logic [IDX_W-1:0]  bit_idx,
  output logic              overrun
);

  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] asm_base;
  logic [WORD_W-1:0] asm_next;
  logic [IDX_W-1:0]  idx_base;
  logic [IDX_W-1:0]  pos;
  logic              complete;
  logic              xfer;

  // align restarts the word before the current bit is placed, so a bit
  // sampled alongside align becomes bit 0 of a fresh word.
  always_comb begin
    idx_base = align ? '0 : bit_idx;
    asm_base = align ? '0 : shreg;
    pos      = LSB_FIRST ? idx_base : IDX_W'(WORD_W-1) - idx_base;
    asm_next = asm_base;
    if (sin_valid) asm_next[pos] = sin;
    complete = sin_valid && !align && (bit_idx == IDX_W'(WORD_W-1));
    xfer     = dout_valid && dout_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_idx    <= '0;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      bit_idx <= sin_valid ? idx_base + IDX_W'(1) : idx_base;
      shreg   <= asm_next;
      if (complete && (!dout_valid || dout_ready)) begin
        dout       <= asm_next;
        dout_valid <= 1'b1;
      end else if (xfer) begin
        dout_valid <= 1'b0;
      end
      // A dropped word outranks a simultaneous clear.
      if (complete && dout_valid && !dout_ready) overrun <= 1'b1;
      else if (ovr_clr)                          overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deser8.sv
// Bench for deser8: both bit orders side by side against a queue-based model.
module tb_deser8;
  import deser8_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0, sin = 1'b0, sin_valid = 1'b0, align = 1'b0;
  logic dout_ready = 1'b0, ovr_clr = 1'b0;
  logic [WORD_W-1:0] dout_l, dout_m;
  logic dv_l, dv_m, ovr_l, ovr_m;
  logic [IDX_W-1:0] idx_l, idx_m;

  int errs = 0;
  int checks = 0;

  // reference model state
  bit   q[$];
  logic [7:0] m_dout_l = '0, m_dout_m = '0;
  logic m_dv = 1'b0, m_ovr = 1'b0;

  always #5 clk = ~clk;

  deser8 #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .align(align),
    .dout_ready(dout_ready), .ovr_clr(ovr_clr), .dout(dout_l), .dout_valid(dv_l),
    .bit_idx(idx_l), .overrun(ovr_l));

  deser8 #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .align(align),
    .dout_ready(dout_ready), .ovr_clr(ovr_clr), .dout(dout_m), .dout_valid(dv_m),
    .bit_idx(idx_m), .overrun(ovr_m));

  // Words are formed from the list of received bits; overrun and the output
  // slot follow the handshake rules.
  task automatic model(input logic r, v, s, a, rdy, clr);
    logic [7:0] wl, wm;
    bit done;
    if (!r) begin
      q.delete();
      m_dout_l = '0; m_dout_m = '0; m_dv = 1'b0; m_ovr = 1'b0;
    end else begin
      done = 1'b0;
      wl = '0; wm = '0;
      if (a) q.delete();
      if (v) q.push_back(s);
      if (q.size() == 8) begin
        done = 1'b1;
        for (int i = 0; i < 8; i++) begin
          wl[i]     = q[i];
          wm[7 - i] = q[i];
        end
        q.delete();
      end
      if (done && m_dv && !rdy) m_ovr = 1'b1;
      else if (clr)             m_ovr = 1'b0;
      if (done && (!m_dv || rdy)) begin
        m_dout_l = wl; m_dout_m = wm; m_dv = 1'b1;
      end else if (m_dv && rdy) begin
        m_dv = 1'b0;
      end
    end
  endtask

  task automatic cyc(input logic r, v, s, a, rdy, clr);
    rst_n = r; sin_valid = v; sin = s; align = a; dout_ready = rdy; ovr_clr = clr;
    @(posedge clk);
    model(r, v, s, a, rdy, clr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // sends w[0] first; readiness may differ on the final bit
  task automatic send_word(input logic [7:0] w, input logic rdy, input logic rdy_last);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b1, w[i], 1'b0, (i == 7) ? rdy_last : rdy, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    do_reset();
    checks++;
    if ({dout_l, dv_l, idx_l, ovr_l, dout_m, dv_m, idx_m, ovr_m} !== '0) begin
      errs++;
      $display("FAIL reset: dout_l=%h dv=%b idx=%0d ovr=%b dout_m=%h, required all zero",
               dout_l, dv_l, idx_l, ovr_l, dout_m);
    end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'h4D;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, w[i], 1'b0, 1'b1, 1'b0);
      if (i == 6) begin
        checks++;
        if (dv_l !== 1'b0 || idx_l !== 3'd7) begin
          errs++;
          $display("FAIL basic_pre: dv=%b idx=%0d, required dv=0 idx=7", dv_l, idx_l);
        end
      end
    end
    checks++;
    if (dout_l !== 8'h4D || dv_l !== 1'b1 || idx_l !== 3'd0) begin
      errs++;
      $display("FAIL basic_lsb: dout=%h dv=%b idx=%0d, required 4d 1 0", dout_l, dv_l, idx_l);
    end
    checks++;
    if (dout_m !== 8'hB2 || dv_m !== 1'b1) begin
      errs++;
      $display("FAIL basic_msb: dout=%h dv=%b, required b2 1", dout_m, dv_m);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dv_l !== 1'b0 || dv_m !== 1'b0) begin
      errs++;
      $display("FAIL basic_one_cycle: dv_l=%b dv_m=%b, required 0 0", dv_l, dv_m);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    w = 8'h4D;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, w[i], 1'b0, 1'b1, 1'b0);
      if (i < 7) begin
        cyc(1'b1, 1'b0, ~w[i], 1'b0, 1'b1, 1'b0);
        checks++;
        if (idx_l !== 3'(i + 1) || dv_l !== 1'b0) begin
          errs++;
          $display("FAIL gap_hold: idx=%0d dv=%b, required idx=%0d dv=0", idx_l, dv_l, i + 1);
        end
      end
    end
    checks++;
    if (dout_l !== 8'h4D || dv_l !== 1'b1) begin
      errs++;
      $display("FAIL gap_word: dout=%h dv=%b, required 4d 1", dout_l, dv_l);
    end
  endtask

  task automatic test_align();
    logic [7:0] w;
    w = 8'hA5;
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, w[0], 1'b1, 1'b1, 1'b0);
    checks++;
    if (idx_l !== 3'd1) begin
      errs++;
      $display("FAIL align_idx: idx=%0d, required 1", idx_l);
    end
    for (int i = 1; i < 8; i++) cyc(1'b1, 1'b1, w[i], 1'b0, 1'b1, 1'b0);
    checks++;
    if (dout_l !== 8'hA5 || dout_m !== 8'hA5 || dv_l !== 1'b1) begin
      errs++;
      $display("FAIL align_word: dout_l=%h dout_m=%h dv=%b, required a5 a5 1", dout_l, dout_m, dv_l);
    end
    // align on the eighth bit must restart rather than complete
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (dv_l !== 1'b0 || idx_l !== 3'd1) begin
      errs++;
      $display("FAIL align_at7: dv=%b idx=%0d, required 0 1", dv_l, idx_l);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    checks++;
    if (dout_l !== 8'h11 || dv_l !== 1'b1 || ovr_l !== 1'b1) begin
      errs++;
      $display("FAIL overrun_set: dout=%h dv=%b ovr=%b, required 11 1 1", dout_l, dv_l, ovr_l);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ovr_l !== 1'b0 || dv_l !== 1'b1) begin
      errs++;
      $display("FAIL overrun_clr: ovr=%b dv=%b, required 0 1", ovr_l, dv_l);
    end
    send_word(8'h33, 1'b0, 1'b1);
    checks++;
    if (dout_l !== 8'h33 || dv_l !== 1'b1 || ovr_l !== 1'b0) begin
      errs++;
      $display("FAIL overrun_xfer_load: dout=%h dv=%b ovr=%b, required 33 1 0", dout_l, dv_l, ovr_l);
    end
    // drop a word while clearing: set must win
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ovr_l !== 1'b1 || dout_l !== 8'h33) begin
      errs++;
      $display("FAIL overrun_set_wins: ovr=%b dout=%h, required 1 33", ovr_l, dout_l);
    end
  endtask

  task automatic test_reset_midword();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({dout_l, dv_l, idx_l, ovr_l} !== '0) begin
      errs++;
      $display("FAIL midreset: dout=%h dv=%b idx=%0d ovr=%b, required zeros", dout_l, dv_l, idx_l, ovr_l);
    end
    send_word(8'h5A, 1'b1, 1'b1);
    checks++;
    if (dout_l !== 8'h5A || dout_m !== 8'h5A || dv_l !== 1'b1) begin
      errs++;
      $display("FAIL midreset_word: dout_l=%h dout_m=%h dv=%b, required 5a 5a 1", dout_l, dout_m, dv_l);
    end
  endtask

  task automatic test_random();
    logic r, v, s, a, rdy, clr;
    int bad = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(63) != 0);
      v   = ($urandom_range(9) < 7);
      s   = 1'($urandom);
      a   = ($urandom_range(15) == 0);
      rdy = 1'($urandom);
      clr = ($urandom_range(7) == 0);
      cyc(r, v, s, a, rdy, clr);
      checks++;
      if (dout_l !== m_dout_l || dout_m !== m_dout_m || dv_l !== m_dv || dv_m !== m_dv ||
          ovr_l !== m_ovr || ovr_m !== m_ovr || idx_l !== 3'(q.size()) || idx_m !== 3'(q.size())) begin
        errs++;
        if (bad < 10)
          $display("FAIL random[%0d]: dout_l=%h dout_m=%h dv=%b/%b ovr=%b/%b idx=%0d/%0d, required %h %h %b %b %0d",
                   n, dout_l, dout_m, dv_l, dv_m, ovr_l, ovr_m, idx_l, idx_m,
                   m_dout_l, m_dout_m, m_dv, m_ovr, q.size());
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_align();
    test_overrun();
    test_reset_midword();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
